shared_reg_arbiter: RTL and testbench
=====================================

# shared_reg_arbiter

Round-robin arbiter that gives several requesters controlled, one-at-a-time write access to a single shared output register. It replaces the illegal practice of driving one register from several processes, which `check` flags as a multiple-driver error. Each requester sees a valid/ready handshake, and the register is written by exactly one process. It sits between independent producer blocks and any shared single-bit or multi-bit output.

## Interface
Parameters:
- `NUM_REQ`, default 2: number of requesters. Must be ≥ 2.
- `DATA_W`, default 1: width of the shared register.
- `MAX_BURST`, default 16: maximum beats one owner may hold the lock. Must be ≥ 2.

Ports (`SW` = $clog2(NUM_REQ)):
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-requester valid.
- `req_data`  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- `req_last`  in  NUM_REQ  final beat of the requester's burst. A single-beat write has last=1.
- `req_ready`  out  NUM_REQ  one-hot or zero; the beat transfers when valid & ready.
- `z_data`  out  DATA_W  shared register.
- `z_valid`  out  1  z_data was written in the previous cycle.
- `z_src`  out  SW  index of the last writer.
- `busy`  out  1  state is LOCKED.
- `burst_cut`  out  1  one-cycle pulse when a lock is force-released at MAX_BURST.

## Operation
- States: IDLE and LOCKED. Internal registers are `rr_ptr` (SW bits), `owner` (SW bits) and `beat_cnt` ($clog2(MAX_BURST) bits).
- **IDLE**
  - Grant goes to the first index with req_valid=1, searching from rr_ptr upward and wrapping modulo NUM_REQ.
  - req_ready[g]=1 in the same cycle. All other ready bits are 0.
- **Transfer in IDLE**
  - Load z_data from requester g's data, set z_src=g and z_valid=1.
  - If req_last[g]=1: stay IDLE and set rr_ptr=(g+1) mod NUM_REQ.
  - Otherwise: go to LOCKED with owner=g and beat_cnt=1.
- **LOCKED**
  - req_ready[owner]=req_valid[owner]. All others are 0.
  - Each owner transfer loads z_data and z_src and increments beat_cnt.
  - Owner transfer with last=1: go to IDLE and set rr_ptr=owner+1 (mod NUM_REQ).
  - Owner transfer that is beat MAX_BURST with last=0: go to IDLE, set rr_ptr=owner+1, and pulse burst_cut in the next cycle. The owner re-arbitrates for the rest of its burst.
  - Owner valid=0: no transfer and the lock is held. There is no timeout.
- No transfer in a cycle → z_valid=0 next cycle. z_data and z_src hold their values.
- Requests with no grant are not dropped; requesters keep valid high.
- Fairness: in IDLE, any waiting requester is granted within NUM_REQ-1 grants, each of at most MAX_BURST beats.

## Timing
- Reset values: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0, z_data=0, z_valid=0, z_src=0, busy=0, burst_cut=0.
- req_ready is forced to 0 while reset=1.
- req_ready is combinational from state, owner, rr_ptr and req_valid. There is no combinational path from req_data or req_last to req_ready.
- Write latency is 1 cycle: a transfer at edge N makes z_data/z_valid/z_src visible after edge N.
- Throughput is 1 beat per cycle.
  - Consecutive single-beat grants to different requesters have no bubble.
  - A burst release to the next requester has no bubble: last beat at N, next requester granted at N+1.
- busy reflects the registered state: high from the cycle after the first non-last beat until the cycle after the releasing beat.
- Reset mid-burst: the lock is dropped and the next arbitration starts from index 0.

## Structure
- Package `shared_reg_arb_pkg` holds:
  - the state enum `arb_state_t` (ARB_IDLE, ARB_LOCKED);
  - function `rr_next(ptr, n)` returning (ptr+1) mod n.
- Sub-module `rr_pick` is combinational. It takes the request vector and rr_ptr and returns a one-hot grant and its index. It is parameterized by NUM_REQ.
- The top module holds the FSM, counters and the single always block that writes z_data.

## Test plan
- **Reset defaults:** reset held 2 cycles with all req_valid=1 → req_ready=0; after release z_data=0, z_valid=0, z_src=0, busy=0.
- **Round-robin alternation:** NUM_REQ=2, both valid every cycle with last=1, data a=1, b=0 → grants alternate 0,1,0,1 from reset; z_data sequence 1,0,1,0; z_src 0,1,0,1.
- **Lock and release:** requester 1 sends a 3-beat burst (last on beat 3) while requester 0 stays valid → req_ready[0]=0 for all 3 beats; busy high; requester 0 granted in the cycle after beat 3.
- **Owner stall:** owner valid drops for 2 cycles mid-burst → z_valid=0 for those cycles; z_data holds; lock retained; others still not ready.
- **Forced release:** MAX_BURST=4 and requester 0 sends 6 beats with last only on beat 6 → release after beat 4; burst_cut pulses once; requester 1 granted next if valid; requester 0 finishes beats 5–6 after re-grant.
- **Reset mid-burst:** reset asserted during beat 2 of a lock held by owner 1 → next cycle after reset, state=IDLE and arbitration starts at index 0.

Source files
------------

// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
//   arb_state_t : arbitration FSM states (free vs. locked to one owner)
//   rr_next     : round-robin successor, (ptr + 1) mod n
package shared_reg_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE   = 1'b0,
    ARB_LOCKED = 1'b1
  } arb_state_t;

  function automatic int rr_next(input int ptr, input int n);
    return (ptr + 32'sd1) % n;
  endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Bundle of requester handshakes and shared-register outputs.
//   req_valid/req_data/req_last : per-requester beat offer
//   req_ready                   : per-requester accept (one-hot or zero)
//   z_data/z_valid/z_src        : shared register, write strobe, last writer
//   busy/burst_cut              : lock status and forced-release pulse
// master = producers side, slave = arbiter side.
interface shared_reg_arbiter_if
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int DATA_W  = 1,
  parameter int SW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         z_data;
  logic                      z_valid;
  logic [SW-1:0]             z_src;
  logic                      busy;
  logic                      burst_cut;

  modport master (
    output req_valid, req_data, req_last,
    input  req_ready, z_data, z_valid, z_src, busy, burst_cut
  );

  modport slave (
    input  req_valid, req_data, req_last,
    output req_ready, z_data, z_valid, z_src, busy, burst_cut
  );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Combinational round-robin picker.
//   req   : request vector
//   ptr   : index with highest priority this cycle
//   grant : one-hot grant (zero when no request)
//   idx   : index of the granted requester (0 when no request)
module rr_pick
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int SW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [SW-1:0]      ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [SW-1:0]      idx
);

  logic          found_s;
  logic [SW-1:0] cand_s;

  // Scan from ptr upward with wrap; the first requester seen wins.
  always_comb begin
    grant   = '0;
    idx     = '0;
    found_s = 1'b0;
    cand_s  = '0;
    for (int off = 0; off < NUM_REQ; off++) begin
      cand_s = SW'((int'(ptr) + off) % NUM_REQ);
      if (!found_s && req[cand_s]) begin
        found_s       = 1'b1;
        grant[cand_s] = 1'b1;
        idx           = cand_s;
      end else begin
        found_s = found_s;
      end
    end
  end

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter giving several producers one-at-a-time write access
// to a single shared register. A non-last beat locks the arbiter to its
// owner until the owner's last beat or until MAX_BURST beats, whichever
// comes first.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : slave side of shared_reg_arbiter_if (handshakes + register)
module shared_reg_arbiter
  import shared_reg_arb_pkg::*;
#(
  parameter int NUM_REQ   = 2,
  parameter int DATA_W    = 1,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  shared_reg_arbiter_if.slave  bus
);

  localparam int SW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_BURST);
  // beat_cnt holds beats already taken, so this value means "this is beat MAX_BURST"
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_BURST - 1);

  arb_state_t          state_r, state_n_s;
  logic [SW-1:0]       rr_ptr_r, rr_ptr_n_s;
  logic [SW-1:0]       owner_r, owner_n_s;
  logic [CW-1:0]       beat_cnt_r, beat_cnt_n_s;
  logic                burst_cut_r, burst_cut_n_s;
  logic [DATA_W-1:0]   z_data_r;
  logic                z_valid_r;
  logic [SW-1:0]       z_src_r;

  logic [NUM_REQ-1:0]  pick_grant_s;
  logic [SW-1:0]       pick_idx_s;
  logic [NUM_REQ-1:0]  ready_s;
  logic                xfer_s;
  logic [SW-1:0]       xfer_idx_s;
  logic                xfer_last_s;
  logic [DATA_W-1:0]   xfer_data_s;
  logic [SW-1:0]       xfer_next_s;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .SW      (SW)
  ) u_pick (
    .req   (bus.req_valid),
    .ptr   (rr_ptr_r),
    .grant (pick_grant_s),
    .idx   (pick_idx_s)
  );

  // Ready depends only on state, owner, rr_ptr and req_valid.
  always_comb begin
    ready_s = '0;
    if (reset) begin
      ready_s = '0;
    end else begin
      case (state_r)
        ARB_IDLE:   ready_s = pick_grant_s;
        ARB_LOCKED: ready_s[owner_r] = bus.req_valid[owner_r];
        default:    ready_s = '0;
      endcase
    end
  end

  // Select the beat that moves this cycle.
  always_comb begin
    if (state_r == ARB_LOCKED) begin
      xfer_idx_s = owner_r;
    end else begin
      xfer_idx_s = pick_idx_s;
    end
    xfer_s      = |(ready_s & bus.req_valid);
    xfer_last_s = bus.req_last[xfer_idx_s];
    xfer_data_s = bus.req_data[xfer_idx_s*DATA_W +: DATA_W];
    xfer_next_s = SW'(rr_next(int'(xfer_idx_s), NUM_REQ));
  end

  // Next-state logic for lock, round-robin pointer and beat counting.
  always_comb begin
    state_n_s     = state_r;
    rr_ptr_n_s    = rr_ptr_r;
    owner_n_s     = owner_r;
    beat_cnt_n_s  = beat_cnt_r;
    burst_cut_n_s = 1'b0;
    case (state_r)
      ARB_IDLE: begin
        if (xfer_s) begin
          if (xfer_last_s) begin
            rr_ptr_n_s = xfer_next_s;
          end else begin
            state_n_s    = ARB_LOCKED;
            owner_n_s    = xfer_idx_s;
            beat_cnt_n_s = CW'(32'd1);
          end
        end else begin
          state_n_s = ARB_IDLE;
        end
      end
      ARB_LOCKED: begin
        if (xfer_s) begin
          if (xfer_last_s) begin
            state_n_s    = ARB_IDLE;
            rr_ptr_n_s   = xfer_next_s;
            beat_cnt_n_s = '0;
          end else if (beat_cnt_r == LAST_CNT) begin
            // Burst too long: drop the lock so others get a turn.
            state_n_s     = ARB_IDLE;
            rr_ptr_n_s    = xfer_next_s;
            beat_cnt_n_s  = '0;
            burst_cut_n_s = 1'b1;
          end else begin
            beat_cnt_n_s = beat_cnt_r + CW'(32'd1);
          end
        end else begin
          // Owner stalled: keep the lock, no timeout.
          state_n_s = ARB_LOCKED;
        end
      end
      default: begin
        state_n_s    = ARB_IDLE;
        rr_ptr_n_s   = '0;
        owner_n_s    = '0;
        beat_cnt_n_s = '0;
      end
    endcase
  end

  // Control state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ARB_IDLE;
      rr_ptr_r    <= '0;
      owner_r     <= '0;
      beat_cnt_r  <= '0;
      burst_cut_r <= 1'b0;
      z_valid_r   <= 1'b0;
      z_src_r     <= '0;
    end else begin
      state_r     <= state_n_s;
      rr_ptr_r    <= rr_ptr_n_s;
      owner_r     <= owner_n_s;
      beat_cnt_r  <= beat_cnt_n_s;
      burst_cut_r <= burst_cut_n_s;
      z_valid_r   <= xfer_s;
      if (xfer_s) begin
        z_src_r <= xfer_idx_s;
      end else begin
        z_src_r <= z_src_r;
      end
    end
  end

  // The one and only writer of the shared register.
  always_ff @(posedge clk) begin
    if (reset) begin
      z_data_r <= '0;
    end else if (xfer_s) begin
      z_data_r <= xfer_data_s;
    end else begin
      z_data_r <= z_data_r;
    end
  end

  assign bus.req_ready = ready_s;
  assign bus.z_data    = z_data_r;
  assign bus.z_valid   = z_valid_r;
  assign bus.z_src     = z_src_r;
  assign bus.busy      = (state_r == ARB_LOCKED);
  assign bus.burst_cut = burst_cut_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Bench for shared_reg_arbiter (NUM_REQ=2, DATA_W=8, MAX_BURST=4).
// A lock/owner model is checked against the DUT on every falling edge;
// the directed sequence adds literal expectations at chosen points.
module tb_shared_reg_arbiter;

  localparam int N  = 2;
  localparam int DW = 8;
  localparam int MB = 4;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_errors;

  shared_reg_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

  shared_reg_arbiter #(
    .NUM_REQ   (N),
    .DATA_W    (DW),
    .MAX_BURST (MB)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks = n_checks + 1;
    if (act !== exp) begin
      n_errors = n_errors + 1;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  int          m_owner = -1;   // -1 means no lock
  int          m_beats = 0;
  int          m_ptr   = 0;
  logic [DW-1:0] e_zdata = '0;
  logic        e_zvalid = 1'b0;
  int          e_zsrc   = 0;
  logic        e_cut    = 1'b0;

  // Compare current outputs, then advance the model with the inputs that
  // the next rising edge will see.
  always @(negedge clk) begin
    logic [N-1:0] r;
    int g;
    r = '0;
    g = -1;
    if (!reset) begin
      if (m_owner >= 0) begin
        r[m_owner] = bus.req_valid[m_owner];
      end else begin
        for (int k = 0; k < N; k++) begin
          if (g < 0 && bus.req_valid[(m_ptr + k) % N]) g = (m_ptr + k) % N;
        end
        if (g >= 0) r[g] = 1'b1;
      end
    end
    chk("m_ready", 32'(bus.req_ready), 32'(r));
    chk("m_zdata", 32'(bus.z_data), 32'(e_zdata));
    chk("m_zvalid", 32'(bus.z_valid), 32'(e_zvalid));
    chk("m_zsrc", 32'(bus.z_src), 32'(e_zsrc));
    chk("m_busy", 32'(bus.busy), 32'(m_owner >= 0));
    chk("m_cut", 32'(bus.burst_cut), 32'(e_cut));

    e_cut = 1'b0;
    if (reset) begin
      m_owner = -1; m_beats = 0; m_ptr = 0;
      e_zdata = '0; e_zvalid = 1'b0; e_zsrc = 0;
    end else if ((r & bus.req_valid) != '0) begin
      g = (m_owner >= 0) ? m_owner : g;
      e_zdata  = bus.req_data[g*DW +: DW];
      e_zvalid = 1'b1;
      e_zsrc   = g;
      if (m_owner < 0) begin
        if (bus.req_last[g]) m_ptr = (g + 1) % N;
        else begin m_owner = g; m_beats = 1; end
      end else begin
        m_beats = m_beats + 1;
        if (bus.req_last[g]) begin
          m_ptr = (g + 1) % N; m_owner = -1;
        end else if (m_beats == MB) begin
          m_ptr = (g + 1) % N; m_owner = -1; e_cut = 1'b1;
        end
      end
    end else begin
      e_zvalid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input logic v0, input logic [7:0] d0, input logic l0,
                       input logic v1, input logic [7:0] d1, input logic l1);
    bus.req_valid = {v1, v0};
    bus.req_data  = {d1, d0};
    bus.req_last  = {l1, l0};
  endtask

  task automatic half();
    @(negedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    reset = 1'b1;
    drive(1'b1, 8'h00, 1'b1, 1'b1, 8'h00, 1'b1);
    half(); chk("rst_ready0", 32'(bus.req_ready), 32'd0);
    tick();
    half(); chk("rst_ready1", 32'(bus.req_ready), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 8'h01, 1'b1, 1'b1, 8'h00, 1'b1);
    half();
    chk("rst_zdata", 32'(bus.z_data), 32'd0);
    chk("rst_zvalid", 32'(bus.z_valid), 32'd0);
    chk("rst_zsrc", 32'(bus.z_src), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rr_ready0", 32'(bus.req_ready), 32'd1);

    // Round-robin alternation, single-beat writes.
    for (int k = 1; k <= 4; k++) begin
      tick(); half();
      chk("rr_zdata", 32'(bus.z_data), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("rr_zsrc", 32'(bus.z_src), (k % 2 == 1) ? 32'd0 : 32'd1);
      chk("rr_zvalid", 32'(bus.z_valid), 32'd1);
      chk("rr_ready", 32'(bus.req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
    end

    // Lock and release: requester 1 3-beat burst, requester 0 waiting.
    tick(); drive(1'b0, 8'h00, 1'b0, 1'b1, 8'hB1, 1'b0);
    half(); chk("lk_ready_a", 32'(bus.req_ready), 32'd2);
    tick(); drive(1'b1, 8'hA0, 1'b1, 1'b1, 8'hB2, 1'b0);
    half();
    chk("lk_ready_b", 32'(bus.req_ready), 32'd2);
    chk("lk_busy_b", 32'(bus.busy), 32'd1);
    chk("lk_zdata_b", 32'(bus.z_data), 32'hB1);
    chk("lk_zsrc_b", 32'(bus.z_src), 32'd1);
    tick(); drive(1'b1, 8'hA0, 1'b1, 1'b1, 8'hB3, 1'b1);
    half();
    chk("lk_ready_c", 32'(bus.req_ready), 32'd2);
    chk("lk_zdata_c", 32'(bus.z_data), 32'hB2);
    tick(); drive(1'b1, 8'hA0, 1'b1, 1'b1, 8'hB4, 1'b1);
    half();
    chk("lk_release_ready", 32'(bus.req_ready), 32'd1);
    chk("lk_release_busy", 32'(bus.busy), 32'd0);
    chk("lk_zdata_d", 32'(bus.z_data), 32'hB3);

    // Owner stall.
    tick(); drive(1'b0, 8'hA0, 1'b1, 1'b1, 8'hC1, 1'b0);
    half();
    chk("st_zdata_a", 32'(bus.z_data), 32'hA0);
    chk("st_ready_a", 32'(bus.req_ready), 32'd2);
    tick(); drive(1'b1, 8'hA1, 1'b1, 1'b0, 8'hC1, 1'b0);
    half();
    chk("st_ready_b", 32'(bus.req_ready), 32'd0);
    chk("st_zdata_b", 32'(bus.z_data), 32'hC1);
    tick();
    half();
    chk("st_zvalid_c", 32'(bus.z_valid), 32'd0);
    chk("st_zdata_c", 32'(bus.z_data), 32'hC1);
    chk("st_busy_c", 32'(bus.busy), 32'd1);
    tick(); drive(1'b1, 8'hA1, 1'b1, 1'b1, 8'hC2, 1'b1);
    half();
    chk("st_zvalid_d", 32'(bus.z_valid), 32'd0);
    chk("st_ready_d", 32'(bus.req_ready), 32'd2);
    tick(); drive(1'b1, 8'hA1, 1'b1, 1'b0, 8'hC2, 1'b1);
    half();
    chk("st_zdata_e", 32'(bus.z_data), 32'hC2);
    chk("st_ready_e", 32'(bus.req_ready), 32'd1);

    // Forced release at MAX_BURST=4 on a 6-beat burst from requester 0.
    tick(); drive(1'b1, 8'hD1, 1'b0, 1'b0, 8'h00, 1'b1);
    half(); chk("fr_zdata_a", 32'(bus.z_data), 32'hA1);
    tick(); drive(1'b1, 8'hD2, 1'b0, 1'b1, 8'hE1, 1'b1);
    half(); chk("fr_ready_b", 32'(bus.req_ready), 32'd1);
    tick(); drive(1'b1, 8'hD3, 1'b0, 1'b1, 8'hE1, 1'b1);
    half(); chk("fr_busy_c", 32'(bus.busy), 32'd1);
    tick(); drive(1'b1, 8'hD4, 1'b0, 1'b1, 8'hE1, 1'b1);
    half(); chk("fr_zdata_d", 32'(bus.z_data), 32'hD3);
    tick(); drive(1'b1, 8'hD5, 1'b0, 1'b1, 8'hE1, 1'b1);
    half();
    chk("fr_cut", 32'(bus.burst_cut), 32'd1);
    chk("fr_busy_e", 32'(bus.busy), 32'd0);
    chk("fr_ready_e", 32'(bus.req_ready), 32'd2);
    chk("fr_zdata_e", 32'(bus.z_data), 32'hD4);
    tick(); drive(1'b1, 8'hD5, 1'b0, 1'b0, 8'hE1, 1'b1);
    half();
    chk("fr_cut_once", 32'(bus.burst_cut), 32'd0);
    chk("fr_zsrc_f", 32'(bus.z_src), 32'd1);
    chk("fr_zdata_f", 32'(bus.z_data), 32'hE1);
    tick(); drive(1'b1, 8'hD6, 1'b1, 1'b0, 8'h00, 1'b1);
    half(); chk("fr_zdata_g", 32'(bus.z_data), 32'hD5);
    tick(); drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1);
    half();
    chk("fr_zdata_h", 32'(bus.z_data), 32'hD6);
    chk("fr_busy_h", 32'(bus.busy), 32'd0);

    // Reset during beat 2 of a lock held by requester 1.
    tick(); drive(1'b1, 8'h61, 1'b1, 1'b1, 8'hF1, 1'b0);
    half(); chk("mr_ready_a", 32'(bus.req_ready), 32'd2);
    tick(); reset = 1'b1; drive(1'b1, 8'h61, 1'b1, 1'b1, 8'hF2, 1'b0);
    half(); chk("mr_ready_rst", 32'(bus.req_ready), 32'd0);
    tick(); reset = 1'b0; drive(1'b1, 8'h61, 1'b1, 1'b1, 8'hF3, 1'b1);
    half();
    chk("mr_busy", 32'(bus.busy), 32'd0);
    chk("mr_zdata", 32'(bus.z_data), 32'd0);
    chk("mr_ready_idx0", 32'(bus.req_ready), 32'd1);
    tick();
    half();
    chk("mr_zdata_g", 32'(bus.z_data), 32'h61);
    chk("mr_zsrc_g", 32'(bus.z_src), 32'd0);
    tick(); drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
    half();
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
